// File: rtl/hier_seq_pkg.sv
// Shared types and helpers for the hierarchy child sequencer.
package hier_seq_pkg;

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, NEXT, FINISH} seq_state_e;

  typedef enum logic {SEQ_MODE_SERIAL, SEQ_MODE_PARALLEL} seq_mode_e;

  // Widest child vector the priority encoder handles.
  localparam int unsigned MaxChild = 32;

  function automatic int unsigned lowest_set_idx(input logic [MaxChild-1:0] vec);
    lowest_set_idx = 0;
    for (int i = int'(MaxChild) - 1; i >= 0; i--) begin
      if (vec[i]) lowest_set_idx = unsigned'(i);
    end
  endfunction

endpackage

// File: rtl/hier_child_sequencer_if.sv
// Child-side start/done bus between the sequencer (master) and its children (slave).
interface hier_child_sequencer_if #(
  parameter int unsigned NUM_CHILD = 5
);

  logic [NUM_CHILD-1:0] child_start;
  logic [NUM_CHILD-1:0] child_done;

  modport master (output child_start, input child_done);
  modport slave  (input child_start, output child_done);

endinterface

// File: rtl/hier_seq_timeout.sv
// Loadable down-counter; expire pulses on the last counted cycle while enabled.
module hier_seq_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = CntW'(TIMEOUT_CYCLES);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == CntW'(1));

endmodule

// File: rtl/hier_child_sequencer.sv
// Start/done orchestrator for NUM_CHILD children, serial or parallel launch.
// Optional per-launch timeout when HIER_SEQ_TIMEOUT_EN is defined. NUM_CHILD must be <= 32.
module hier_child_sequencer
  import hier_seq_pkg::*;
#(
  parameter int unsigned NUM_CHILD      = 5,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned IDX_W         = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   mode_i,
  input  logic [NUM_CHILD-1:0]   child_mask_i,
  hier_child_sequencer_if.master child_bus,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [IDX_W-1:0]       cur_idx_o
);

  seq_state_e           state_q, state_d;
  seq_mode_e            mode_q, mode_d;
  logic [NUM_CHILD-1:0] pending_q, pending_d;
  logic [IDX_W-1:0]     cur_idx_q, cur_idx_d;
  logic                 err_q, err_d;
  logic [NUM_CHILD-1:0] child_start;
  logic [IDX_W-1:0]     launch_idx;
  logic                 tmo_expire;

  assign launch_idx = IDX_W'(lowest_set_idx(MaxChild'(pending_q)));

`ifdef HIER_SEQ_TIMEOUT_EN
  logic tmo_load, tmo_clear, tmo_en;

  assign tmo_load  = (state_q == LAUNCH);
  assign tmo_en    = (state_q == WAIT);
  assign tmo_clear = (state_q == FINISH);

  hier_seq_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .load_i  (tmo_load),
    .clear_i (tmo_clear),
    .en_i    (tmo_en),
    .expire_o(tmo_expire)
  );
`else
  logic unused_timeout;

  assign tmo_expire     = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    pending_d   = pending_q;
    cur_idx_d   = cur_idx_q;
    err_d       = err_q;
    child_start = '0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          mode_d    = seq_mode_e'(mode_i);
          pending_d = child_mask_i;
          err_d     = 1'b0;
          state_d   = LAUNCH;
        end
      end
      LAUNCH: begin
        // Done pulses seen here are ignored: a child cannot finish in its own launch cycle.
        if (pending_q == '0) begin
          state_d = FINISH;
        end else begin
          state_d = WAIT;
          if (mode_q == SEQ_MODE_SERIAL) begin
            child_start[launch_idx] = 1'b1;
            cur_idx_d               = launch_idx;
          end else begin
            child_start = pending_q;
          end
        end
      end
      WAIT: begin
        if (mode_q == SEQ_MODE_SERIAL) begin
          if (child_bus.child_done[cur_idx_q]) begin
            pending_d[cur_idx_q] = 1'b0;
            state_d              = NEXT;
          end
        end else begin
          pending_d = pending_q & ~child_bus.child_done;
          if (pending_d == '0) state_d = FINISH;
        end
        // A completion in the expiry cycle wins over the timeout.
        if ((state_d == WAIT) && tmo_expire) begin
          err_d     = 1'b1;
          pending_d = '0;
          state_d   = FINISH;
        end
      end
      NEXT: begin
        state_d = (pending_q != '0) ? LAUNCH : FINISH;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= SEQ_MODE_SERIAL;
      pending_q <= '0;
      cur_idx_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      pending_q <= pending_d;
      cur_idx_q <= cur_idx_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    cur_idx_o = '0;
    if (mode_q == SEQ_MODE_SERIAL) begin
      if (state_q == LAUNCH) cur_idx_o = launch_idx;
      else if (state_q == WAIT) cur_idx_o = cur_idx_q;
    end
  end

  assign child_bus.child_start = child_start;
  assign busy_o                = (state_q != IDLE);
  assign done_o                = (state_q == FINISH);
  assign err_o                 = err_q;

endmodule
